// File: rtl/ariane_soc_pkg.sv
// SoC address map, target indices and decode rules shared by the peripheral arbiter.
package ariane_soc;

  localparam int unsigned NrSlaves  = 2;
  localparam int unsigned NrRegions = 5;

  typedef enum logic [2:0] {
    DRAM  = 3'd0,
    PERIP = 3'd1,
    UART  = 3'd2,
    CLINT = 3'd3,
    Debug = 3'd4
  } axi_slaves_t;

  localparam logic [63:0] DebugBase   = 64'h0000_0000_0000_0000;
  localparam logic [63:0] DebugLength = 64'h0000_0000_0000_1000;
  localparam logic [63:0] ClintBase   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ClintLength = 64'h0000_0000_000C_0000;
  localparam logic [63:0] UartBase    = 64'h0000_0000_1000_0000;
  localparam logic [63:0] UartLength  = 64'h0000_0000_0000_1000;
  localparam logic [63:0] PeripBase   = 64'h0000_0000_4000_0000;
  localparam logic [63:0] PeripLength = 64'h0000_0000_2000_0000;
  localparam logic [63:0] DramBase    = 64'h0000_0000_8000_0000;
  localparam logic [63:0] DramLength  = 64'h0000_0000_4000_0000;

  typedef struct packed {
    logic [63:0] base;
    logic [63:0] length;
    axi_slaves_t idx;
  } addr_rule_t;

  // Entry i describes target i, so the array follows axi_slaves_t order.
  localparam addr_rule_t AddrMap [NrRegions] = '{
    '{base: DramBase,  length: DramLength,  idx: DRAM},
    '{base: PeripBase, length: PeripLength, idx: PERIP},
    '{base: UartBase,  length: UartLength,  idx: UART},
    '{base: ClintBase, length: ClintLength, idx: CLINT},
    '{base: DebugBase, length: DebugLength, idx: Debug}
  };

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_DERR = 2'd3
  } arb_state_e;

  function automatic logic addr_in_rule(input logic [63:0] addr, input addr_rule_t rule);
    return (addr >= rule.base) && (addr < (rule.base + rule.length));
  endfunction

endpackage

// File: rtl/soc_addr_decoder.sv
// Combinational address decode against the SoC map: hit flag plus target index.
module soc_addr_decoder
  import ariane_soc::*;
(
  input  logic [63:0] addr_i,
  output logic        hit_o,
  output logic [2:0]  idx_o
);

  always_comb begin
    hit_o = 1'b0;
    idx_o = 3'd0;
    for (int i = 0; i < int'(NrRegions); i++) begin
      if (addr_in_rule(addr_i, AddrMap[i])) begin
        hit_o = 1'b1;
        idx_o = 3'(AddrMap[i].idx);
      end
    end
  end

endmodule

// File: rtl/soc_periph_arbiter.sv
// Round-robin share of one peripheral request port between crossbar masters, with
// address decode, local error response for unmapped addresses and a hang watchdog.
module soc_periph_arbiter
  import ariane_soc::*;
#(
  parameter int unsigned NrMasters     = ariane_soc::NrSlaves,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NrMasters-1:0] m_req_i,
  input  logic [63:0]          m_addr_i  [NrMasters],
  input  logic [NrMasters-1:0] m_we_i,
  input  logic [63:0]          m_wdata_i [NrMasters],
  input  logic [7:0]           m_be_i    [NrMasters],
  output logic [NrMasters-1:0] m_gnt_o,
  output logic [NrMasters-1:0] m_rvalid_o,
  output logic [63:0]          m_rdata_o,
  output logic                 m_err_o,
  output logic                 req_o,
  output logic [2:0]           slv_idx_o,
  output logic [63:0]          addr_o,
  output logic                 we_o,
  output logic [63:0]          wdata_o,
  output logic [7:0]           be_o,
  input  logic                 gnt_i,
  input  logic                 rvalid_i,
  input  logic [63:0]          rdata_i,
  input  logic                 err_i
);

  localparam int unsigned IdxW = (NrMasters > 1) ? $clog2(NrMasters) : 1;
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  arb_state_e      state_q, state_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [63:0]     addr_q, addr_d;
  logic            we_q, we_d;
  logic [63:0]     wdata_q, wdata_d;
  logic [7:0]      be_q, be_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [63:0]     rsp_data_q, rsp_data_d;

  logic            found;
  logic [IdxW-1:0] win;
  int unsigned     cand;
  logic            dec_hit;
  logic [2:0]      dec_idx;
  logic            timeout;

  // First requester at or after the round-robin pointer wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int unsigned i = 0; i < NrMasters; i++) begin
      cand = (int'(rr_q) + i) % NrMasters;
      if (!found && m_req_i[cand]) begin
        found = 1'b1;
        win   = IdxW'(cand);
      end
    end
  end

  soc_addr_decoder u_decoder (
    .addr_i (m_addr_i[win]),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    m_gnt_o     = '0;

    unique case (state_q)
      ARB_IDLE: begin
        // Gated by reset so the grant pulse cannot escape while the block is held in reset.
        if (found && rst_ni) begin
          m_gnt_o[win] = 1'b1;
          owner_d      = win;
          addr_d       = m_addr_i[win];
          we_d         = m_we_i[win];
          wdata_d      = m_wdata_i[win];
          be_d         = m_be_i[win];
          idx_d        = dec_idx;
          rr_d         = (win == IdxW'(NrMasters - 1)) ? '0 : win + IdxW'(1);
          if (dec_hit) begin
            state_d = ARB_REQ;
          end else begin
            state_d     = ARB_DERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      ARB_REQ: begin
        if (gnt_i) begin
          state_d = ARB_RESP;
        end else if (timeout) begin
          state_d     = ARB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ARB_RESP: begin
        if (rvalid_i) begin
          state_d     = ARB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_i;
          rsp_data_d  = rdata_i;
        end else if (timeout) begin
          state_d     = ARB_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      ARB_DERR: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Counter restarts whenever REQ or RESP is entered and runs only while staying there.
  always_comb begin
    cnt_d = '0;
    if ((state_q == ARB_REQ && state_d == ARB_REQ) ||
        (state_q == ARB_RESP && state_d == ARB_RESP)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ARB_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  for (genvar gi = 0; gi < int'(NrMasters); gi++) begin : g_rvalid
    assign m_rvalid_o[gi] = rsp_valid_q && (owner_q == IdxW'(gi));
  end

  assign m_rdata_o = rsp_data_q;
  assign m_err_o   = rsp_err_q;
  assign req_o     = (state_q == ARB_REQ);
  assign slv_idx_o = idx_q;
  assign addr_o    = addr_q;
  assign we_o      = we_q;
  assign wdata_o   = wdata_q;
  assign be_o      = be_q;

endmodule

// File: tb/tb_soc_periph_arbiter.sv
// Directed self-checking bench for soc_periph_arbiter (2 masters, 8-cycle watchdog).
module tb_soc_periph_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [63:0] m_addr  [2];
  logic [1:0]  m_we;
  logic [63:0] m_wdata [2];
  logic [7:0]  m_be    [2];
  logic [1:0]  m_gnt;
  logic [1:0]  m_rvalid;
  logic [63:0] m_rdata;
  logic        m_err;
  logic        req;
  logic [2:0]  slv_idx;
  logic [63:0] addr;
  logic        we;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  soc_periph_arbiter #(.NrMasters(2), .TimeoutCycles(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_wdata_i(m_wdata), .m_be_i(m_be),
    .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .req_o(req), .slv_idx_o(slv_idx), .addr_o(addr), .we_o(we), .wdata_o(wdata), .be_o(be),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "bench timeout");
  end

  // Inputs are driven at the falling edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = 2'b11; m_we = 2'b00; gnt = 0; rvalid = 0; rdata = '0; err = 0;
    m_addr[0] = 64'h8000_0000; m_addr[1] = 64'h8000_0000;
    m_wdata[0] = '0; m_wdata[1] = '0; m_be[0] = 8'hFF; m_be[1] = 8'hFF;
    cyc(); cyc(); #1;
    n_checks++; if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", m_gnt); end
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", m_rvalid); end
    n_checks++; if (req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", req); end
    n_checks++; if (m_rdata !== 64'h0 || m_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp: got %h/%b expected 0/0", m_rdata, m_err); end
    n_checks++; if (addr !== 64'h0 || slv_idx !== 3'd0 || we !== 1'b0 || be !== 8'h0 || wdata !== 64'h0) begin
      n_fail++; $display("FAIL reset_fields: got addr %h idx %0d we %b be %h expected all 0", addr, slv_idx, we, be); end
    cyc(); m_req = 2'b00; rst_n = 1'b1; #1;
    n_checks++; if (m_gnt !== 2'b00 || req !== 1'b0) begin n_fail++; $display("FAIL reset_release: got gnt %b req %b expected 00/0", m_gnt, req); end
    $display("reset: outputs checked during and after reset");
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    cyc(); m_req = 2'b11; m_addr[0] = 64'h8000_0000; m_addr[1] = 64'h8000_0100; #1;
    n_checks++; if (m_gnt !== exp_g[0]) begin n_fail++; $display("FAIL contention_gnt0: got %b expected %b", m_gnt, exp_g[0]); end
    for (int k = 0; k < 4; k++) begin
      cyc(); gnt = 1; #1;
      n_checks++; if (req !== 1'b1 || m_gnt !== 2'b00) begin n_fail++; $display("FAIL contention_req%0d: got req %b gnt %b expected 1/00", k, req, m_gnt); end
      cyc(); gnt = 0; rvalid = 1; rdata = 64'(100 + k); #1;
      cyc(); rvalid = 0; rdata = '0; if (k == 3) m_req = 2'b00; #1;
      n_checks++; if (m_rvalid !== exp_g[k] || m_rdata !== 64'(100 + k) || m_err !== 1'b0) begin
        n_fail++; $display("FAIL contention_rsp%0d: got %b/%h/%b expected %b/%h/0", k, m_rvalid, m_rdata, m_err, exp_g[k], 64'(100 + k)); end
      n_checks++;
      if (k < 3) begin
        if (m_gnt !== exp_g[k+1]) begin n_fail++; $display("FAIL contention_gnt%0d: got %b expected %b", k + 1, m_gnt, exp_g[k+1]); end
      end else if (m_gnt !== 2'b00) begin n_fail++; $display("FAIL contention_idle: got %b expected 00", m_gnt); end
      $display("contention: transaction %0d owner %b rdata %0d", k, m_rvalid, m_rdata);
    end
  endtask

  task automatic test_single_read();
    cyc(); m_req = 2'b01; m_addr[0] = 64'h1000_0000; m_we[0] = 0; #1;
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b expected 01", m_gnt); end
    cyc(); m_req = 2'b00; gnt = 1; #1;
    n_checks++; if (req !== 1'b1 || slv_idx !== 3'd2 || addr !== 64'h1000_0000) begin
      n_fail++; $display("FAIL read_req: got req %b idx %0d addr %h expected 1/2/10000000", req, slv_idx, addr); end
    cyc(); gnt = 0; rvalid = 1; rdata = 64'hDEAD; #1;
    n_checks++; if (req !== 1'b0 || m_rvalid !== 2'b00) begin n_fail++; $display("FAIL read_wait: got req %b rvalid %b expected 0/00", req, m_rvalid); end
    cyc(); rvalid = 0; rdata = '0; #1;
    n_checks++; if (m_rvalid !== 2'b01 || m_rdata !== 64'hDEAD || m_err !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp: got %b/%h/%b expected 01/dead/0", m_rvalid, m_rdata, m_err); end
    cyc(); #1;
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL read_pulse: got %b expected 00", m_rvalid); end
    $display("single_read: addr 10000000 rdata %h", 64'hDEAD);
  endtask

  task automatic test_decode();
    logic [63:0] va [10];
    logic        vh [10];
    logic [2:0]  vi [10];
    va[0] = 64'h0FFF;        vh[0] = 1; vi[0] = 3'd4;
    va[1] = 64'h0200_0000;   vh[1] = 1; vi[1] = 3'd3;
    va[2] = 64'h020C_0000;   vh[2] = 0; vi[2] = 3'd0;
    va[3] = 64'h1000_0FFF;   vh[3] = 1; vi[3] = 3'd2;
    va[4] = 64'h4000_0000;   vh[4] = 1; vi[4] = 3'd1;
    va[5] = 64'h5FFF_FFFF;   vh[5] = 1; vi[5] = 3'd1;
    va[6] = 64'h6000_0000;   vh[6] = 0; vi[6] = 3'd0;
    va[7] = 64'hBFFF_FFF8;   vh[7] = 1; vi[7] = 3'd0;
    va[8] = 64'hC000_0000;   vh[8] = 0; vi[8] = 3'd0;
    va[9] = 64'h1_8000_0000; vh[9] = 0; vi[9] = 3'd0;
    // Master 1 write to the first byte past the debug region.
    cyc(); m_req = 2'b10; m_addr[1] = 64'h1000; m_we[1] = 1; m_wdata[1] = 64'h1234; m_be[1] = 8'h0F; #1;
    n_checks++; if (m_gnt !== 2'b10) begin n_fail++; $display("FAIL miss_gnt: got %b expected 10", m_gnt); end
    cyc(); m_req = 2'b00; m_we[1] = 0; #1;
    n_checks++; if (req !== 1'b0 || m_rvalid !== 2'b10 || m_err !== 1'b1 || m_rdata !== 64'h0) begin
      n_fail++; $display("FAIL miss_rsp: got req %b rvalid %b err %b rdata %h expected 0/10/1/0", req, m_rvalid, m_err, m_rdata); end
    for (int i = 0; i < 10; i++) begin
      cyc(); m_req = 2'b01; m_addr[0] = va[i]; #1;
      n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL decode_gnt%0d: got %b expected 01", i, m_gnt); end
      cyc(); m_req = 2'b00; gnt = vh[i]; #1;
      if (vh[i]) begin
        n_checks++; if (req !== 1'b1 || slv_idx !== vi[i]) begin
          n_fail++; $display("FAIL decode_idx%0d: got req %b idx %0d expected 1/%0d", i, req, slv_idx, vi[i]); end
        cyc(); gnt = 0; rvalid = 1; rdata = 64'(i); #1;
        cyc(); rvalid = 0; rdata = '0; #1;
        n_checks++; if (m_rvalid !== 2'b01 || m_err !== 1'b0 || m_rdata !== 64'(i)) begin
          n_fail++; $display("FAIL decode_rsp%0d: got %b/%b/%h expected 01/0/%h", i, m_rvalid, m_err, m_rdata, 64'(i)); end
      end else begin
        n_checks++; if (req !== 1'b0 || m_rvalid !== 2'b01 || m_err !== 1'b1 || m_rdata !== 64'h0) begin
          n_fail++; $display("FAIL decode_miss%0d: got req %b rvalid %b err %b expected 0/01/1", i, req, m_rvalid, m_err); end
      end
      $display("decode: addr %h hit %b idx %0d", va[i], vh[i], vi[i]);
    end
  endtask

  task automatic test_timeout_resp();
    cyc(); m_req = 2'b01; m_addr[0] = 64'h8000_0000; #1;
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL toresp_gnt: got %b expected 01", m_gnt); end
    cyc(); m_req = 2'b00; gnt = 1; #1;
    n_checks++; if (req !== 1'b1) begin n_fail++; $display("FAIL toresp_req: got %b expected 1", req); end
    for (int c = 0; c < 8; c++) begin
      cyc(); gnt = 0; #1;
      n_checks++; if (m_rvalid !== 2'b00 || req !== 1'b0) begin n_fail++; $display("FAIL toresp_wait%0d: got rvalid %b req %b expected 00/0", c, m_rvalid, req); end
    end
    cyc(); #1;
    n_checks++; if (m_rvalid !== 2'b01 || m_err !== 1'b1 || m_rdata !== 64'h0) begin
      n_fail++; $display("FAIL toresp_err: got %b/%b/%h expected 01/1/0", m_rvalid, m_err, m_rdata); end
    cyc(); rvalid = 1; rdata = 64'hBAD; #1;
    cyc(); rvalid = 0; rdata = '0; #1;
    n_checks++; if (m_rvalid !== 2'b00 || m_rdata !== 64'h0) begin n_fail++; $display("FAIL toresp_stray: got %b/%h expected 00/0", m_rvalid, m_rdata); end
    $display("timeout_resp: error response after 8 cycles in RESP");
  endtask

  task automatic test_timeout_req();
    cyc(); m_req = 2'b01; m_addr[0] = 64'h4000_0000; #1;
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL toreq_gnt: got %b expected 01", m_gnt); end
    for (int c = 0; c < 8; c++) begin
      cyc(); m_req = 2'b00; #1;
      n_checks++; if (req !== 1'b1 || addr !== 64'h4000_0000 || m_rvalid !== 2'b00) begin
        n_fail++; $display("FAIL toreq_hold%0d: got req %b addr %h rvalid %b expected 1/40000000/00", c, req, addr, m_rvalid); end
    end
    cyc(); #1;
    n_checks++; if (req !== 1'b0 || m_rvalid !== 2'b01 || m_err !== 1'b1 || m_rdata !== 64'h0) begin
      n_fail++; $display("FAIL toreq_err: got req %b rvalid %b err %b rdata %h expected 0/01/1/0", req, m_rvalid, m_err, m_rdata); end
    $display("timeout_req: req dropped after 8 cycles with error");
  endtask

  task automatic test_reset_mid();
    cyc(); m_req = 2'b01; m_addr[0] = 64'h1000_0000; #1;
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_gnt: got %b expected 01", m_gnt); end
    cyc(); m_req = 2'b00; gnt = 1; #1;
    cyc(); gnt = 0; #1;
    cyc(); rst_n = 0; rvalid = 1; rdata = 64'h77; #1;
    n_checks++; if (req !== 1'b0 || m_rvalid !== 2'b00 || m_err !== 1'b0 || m_rdata !== 64'h0 || addr !== 64'h0 || slv_idx !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_outputs: got req %b rvalid %b err %b addr %h expected all 0", req, m_rvalid, m_err, addr); end
    cyc(); rst_n = 1; rvalid = 0; rdata = '0; #1;
    n_checks++; if (m_rvalid !== 2'b00) begin n_fail++; $display("FAIL rstmid_norsp: got %b expected 00", m_rvalid); end
    cyc(); m_req = 2'b11; m_addr[1] = 64'h1000_0000; #1;
    n_checks++; if (m_gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_first: got %b expected 01", m_gnt); end
    cyc(); m_req = 2'b00; #1;
    $display("reset_mid: transaction abandoned, master 0 served first");
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_read();
    test_decode();
    test_timeout_resp();
    test_timeout_req();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
